virtio_mmio_mq: RTL and testbench

VIRTIO_MMIO_MQ -- requirements
Module: virtio_mmio_mq

---
 rtl/virtio_pkg.sv | 38 +++
 rtl/virtio_mmio_mq_if.sv | 34 +++
 rtl/virtio_notify_fifo.sv | 49 ++++
 rtl/virtio_mmio_mq.sv | 224 ++++++++++++++++++++++
 tb/tb_virtio_mmio_mq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/virtio_pkg.sv
// Shared constants and helpers for the virtio MMIO transport: register offsets,
// identification values and the byte-strobe merge used by every RW register.
package virtio_pkg;

  localparam logic [31:0] VirtioMagic    = 32'h7472_6976;
  localparam logic [31:0] VirtioVersion  = 32'd2;
  localparam logic [31:0] VirtioVendorId = 32'd0;

  localparam logic [11:0] AddrMagic       = 12'h000;
  localparam logic [11:0] AddrVersion     = 12'h004;
  localparam logic [11:0] AddrDeviceId    = 12'h008;
  localparam logic [11:0] AddrVendorId    = 12'h00C;
  localparam logic [11:0] AddrQueueSel    = 12'h030;
  localparam logic [11:0] AddrQueueNumMax = 12'h034;
  localparam logic [11:0] AddrQueueNum    = 12'h038;
  localparam logic [11:0] AddrQueueReady  = 12'h044;
  localparam logic [11:0] AddrQueueNotify = 12'h050;
  localparam logic [11:0] AddrIntStatus   = 12'h060;
  localparam logic [11:0] AddrIntAck      = 12'h064;
  localparam logic [11:0] AddrStatus      = 12'h070;
  localparam logic [11:0] AddrQueueDesc   = 12'h080;
  localparam logic [11:0] AddrQueueDriver = 12'h090;
  localparam logic [11:0] AddrQueueDevice = 12'h0A0;
  localparam logic [11:0] AddrOvf         = 12'h0FC;

  localparam logic [1:0] RespOkay = 2'b00;

  function automatic logic [31:0] apply_strb(logic [31:0] old_val, logic [31:0] new_val,
                                             logic [3:0] strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/virtio_mmio_mq_if.sv
// AXI4-Lite register port of the virtio MMIO transport (32-bit address and data).
interface virtio_mmio_mq_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
           rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
           rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/virtio_notify_fifo.sv
// Queue-index FIFO between QueueNotify writes and the backend. A push into a full
// FIFO succeeds when a pop happens in the same cycle; flush empties it.
module virtio_notify_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             empty, do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign valid_o = !empty;
  assign data_o  = mem_q[rptr_q[PtrW-1:0]];
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[PtrW-1:0]] <= data_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/virtio_mmio_mq.sv
// Virtio MMIO (version 2) transport with several virtqueues: AXI4-Lite register file,
// notify FIFO towards the backend and the interrupt status/ack logic.
module virtio_mmio_mq
  import virtio_pkg::*;
#(
  parameter int unsigned NUM_QUEUES    = 2,
  parameter int unsigned QUEUE_NUM_MAX = 8,
  parameter int unsigned NOTIFY_DEPTH  = 4,
  parameter int unsigned DEVICE_ID     = 2,
  localparam int unsigned QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  virtio_mmio_mq_if.slave          core,
  output logic                     notify_valid,
  input  logic                     notify_ready,
  output logic [QW-1:0]            notify_queue,
  input  logic                     irq_raise,
  output logic [NUM_QUEUES-1:0]    q_ready,
  output logic [16*NUM_QUEUES-1:0] q_num,
  output logic [32*NUM_QUEUES-1:0] q_desc,
  output logic [32*NUM_QUEUES-1:0] q_avail,
  output logic [32*NUM_QUEUES-1:0] q_used,
  output logic                     virtio_interrupt
);

  logic [31:0]           queue_sel_q, queue_sel_d;
  logic [7:0]            status_q, status_d;
  logic [1:0]            int_status_q, int_status_d;
  logic                  ovf_q, ovf_d;
  logic [NUM_QUEUES-1:0] ready_q, ready_d;
  logic [15:0]           num_q   [NUM_QUEUES];
  logic [15:0]           num_d   [NUM_QUEUES];
  logic [31:0]           desc_q  [NUM_QUEUES];
  logic [31:0]           desc_d  [NUM_QUEUES];
  logic [31:0]           avail_q [NUM_QUEUES];
  logic [31:0]           avail_d [NUM_QUEUES];
  logic [31:0]           used_q  [NUM_QUEUES];
  logic [31:0]           used_d  [NUM_QUEUES];

  logic        rvalid_q, rvalid_d, bvalid_q, bvalid_d;
  logic [31:0] rdata_q, rd_data;
  logic        rd_en, wr_en, qsel_ok;
  logic [11:0] rd_addr, wr_addr;
  logic [QW-1:0] qidx;

  logic          fifo_push, fifo_flush, fifo_full, fifo_pop;
  logic [31:0]   num_wr, notify_wr;
  logic [7:0]    status_wr;
  logic          dev_reset;

  logic unused_bits;
  assign unused_bits = ^{core.awaddr[31:12], core.araddr[31:12], core.awprot, core.arprot};

  assign rd_addr = core.araddr[11:0];
  assign wr_addr = core.awaddr[11:0];
  assign qsel_ok = (queue_sel_q < NUM_QUEUES);
  assign qidx    = queue_sel_q[QW-1:0];

  // AXI4-Lite handshakes; address and data of a write are only taken together.
  assign rd_en        = core.arvalid && !rvalid_q;
  assign wr_en        = core.awvalid && core.wvalid && !bvalid_q;
  assign core.arready = !rvalid_q;
  assign core.awready = wr_en;
  assign core.wready  = wr_en;
  assign core.rvalid  = rvalid_q;
  assign core.rdata   = rdata_q;
  assign core.rresp   = RespOkay;
  assign core.bvalid  = bvalid_q;
  assign core.bresp   = RespOkay;

  always_comb begin
    rvalid_d = rvalid_q;
    bvalid_d = bvalid_q;
    if (rd_en) rvalid_d = 1'b1;
    else if (rvalid_q && core.rready) rvalid_d = 1'b0;
    if (wr_en) bvalid_d = 1'b1;
    else if (bvalid_q && core.bready) bvalid_d = 1'b0;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      AddrMagic:       rd_data = VirtioMagic;
      AddrVersion:     rd_data = VirtioVersion;
      AddrDeviceId:    rd_data = DEVICE_ID;
      AddrVendorId:    rd_data = VirtioVendorId;
      AddrQueueSel:    rd_data = queue_sel_q;
      AddrQueueNumMax: if (qsel_ok) rd_data = QUEUE_NUM_MAX;
      AddrQueueNum:    if (qsel_ok) rd_data = {16'h0, num_q[qidx]};
      AddrQueueReady:  if (qsel_ok) rd_data = {31'h0, ready_q[qidx]};
      AddrIntStatus:   rd_data = {30'h0, int_status_q};
      AddrStatus:      rd_data = {24'h0, status_q};
      AddrQueueDesc:   if (qsel_ok) rd_data = desc_q[qidx];
      AddrQueueDriver: if (qsel_ok) rd_data = avail_q[qidx];
      AddrQueueDevice: if (qsel_ok) rd_data = used_q[qidx];
      AddrOvf:         rd_data = {31'h0, ovf_q};
      default:         rd_data = '0;
    endcase
  end

  always_comb begin
    queue_sel_d  = queue_sel_q;
    status_d     = status_q;
    int_status_d = int_status_q;
    ovf_d        = ovf_q;
    ready_d      = ready_q;
    num_d        = num_q;
    desc_d       = desc_q;
    avail_d      = avail_q;
    used_d       = used_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    dev_reset    = 1'b0;
    num_wr       = apply_strb({16'h0, num_q[qidx]}, core.wdata, core.wstrb);
    notify_wr    = apply_strb(32'h0, core.wdata, core.wstrb);
    status_wr    = core.wstrb[0] ? core.wdata[7:0] : status_q;

    if (wr_en) begin
      case (wr_addr)
        AddrQueueSel: queue_sel_d = apply_strb(queue_sel_q, core.wdata, core.wstrb);
        AddrQueueNum: begin
          if (qsel_ok && num_wr != 32'h0 && num_wr <= QUEUE_NUM_MAX) num_d[qidx] = num_wr[15:0];
        end
        AddrQueueReady: if (qsel_ok && core.wstrb[0]) ready_d[qidx] = core.wdata[0];
        AddrQueueNotify: begin
          if (notify_wr < NUM_QUEUES && ready_q[notify_wr[QW-1:0]]) fifo_push = 1'b1;
        end
        AddrIntAck: int_status_d = int_status_q & ~(core.wdata[1:0] & {2{core.wstrb[0]}});
        AddrStatus: begin
          status_d = status_wr;
          if (status_wr == 8'h0) dev_reset = 1'b1;
          if (status_wr[6]) int_status_d[1] = 1'b1;
        end
        AddrQueueDesc:   if (qsel_ok) desc_d[qidx] = apply_strb(desc_q[qidx], core.wdata, core.wstrb);
        AddrQueueDriver: if (qsel_ok) avail_d[qidx] = apply_strb(avail_q[qidx], core.wdata, core.wstrb);
        AddrQueueDevice: if (qsel_ok) used_d[qidx] = apply_strb(used_q[qidx], core.wdata, core.wstrb);
        default: ;
      endcase
    end

    if (irq_raise) int_status_d[0] = 1'b1;
    // Read-to-clear first, so an overflow in the same cycle is not lost.
    if (rd_en && rd_addr == AddrOvf) ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;

    if (dev_reset) begin
      queue_sel_d  = '0;
      int_status_d = '0;
      ovf_d        = 1'b0;
      ready_d      = '0;
      num_d        = '{default: '0};
      desc_d       = '{default: '0};
      avail_d      = '{default: '0};
      used_d       = '{default: '0};
      fifo_push    = 1'b0;
      fifo_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
      if (rd_en) rdata_q <= rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      queue_sel_q  <= '0;
      status_q     <= '0;
      int_status_q <= '0;
      ovf_q        <= 1'b0;
      ready_q      <= '0;
      num_q        <= '{default: '0};
      desc_q       <= '{default: '0};
      avail_q      <= '{default: '0};
      used_q       <= '{default: '0};
    end else begin
      queue_sel_q  <= queue_sel_d;
      status_q     <= status_d;
      int_status_q <= int_status_d;
      ovf_q        <= ovf_d;
      ready_q      <= ready_d;
      num_q        <= num_d;
      desc_q       <= desc_d;
      avail_q      <= avail_d;
      used_q       <= used_d;
    end
  end

  assign fifo_pop = notify_valid && notify_ready;

  virtio_notify_fifo #(
    .WIDTH (QW),
    .DEPTH (NOTIFY_DEPTH)
  ) u_notify_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (notify_wr[QW-1:0]),
    .pop_i   (fifo_pop),
    .valid_o (notify_valid),
    .full_o  (fifo_full),
    .data_o  (notify_queue)
  );

  assign q_ready          = ready_q;
  assign virtio_interrupt = |int_status_q;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue_out
    assign q_num[16*g +: 16]   = num_q[g];
    assign q_desc[32*g +: 32]  = desc_q[g];
    assign q_avail[32*g +: 32] = avail_q[g];
    assign q_used[32*g +: 32]  = used_q[g];
  end

endmodule

// File: tb/tb_virtio_mmio_mq.sv
// Directed bench for virtio_mmio_mq with NUM_QUEUES=2, QUEUE_NUM_MAX=8, NOTIFY_DEPTH=4.
module tb_virtio_mmio_mq;

  logic        clk = 1'b0;
  logic        rst;
  logic        notify_valid, notify_ready, irq_raise, virtio_interrupt;
  logic [0:0]  notify_queue;
  logic [1:0]  q_ready;
  logic [31:0] q_num;
  logic [63:0] q_desc, q_avail, q_used;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  virtio_mmio_mq_if bus ();

  virtio_mmio_mq #(
    .NUM_QUEUES    (2),
    .QUEUE_NUM_MAX (8),
    .NOTIFY_DEPTH  (4),
    .DEVICE_ID     (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .core             (bus),
    .notify_valid     (notify_valid),
    .notify_ready     (notify_ready),
    .notify_queue     (notify_queue),
    .irq_raise        (irq_raise),
    .q_ready          (q_ready),
    .q_num            (q_num),
    .q_desc           (q_desc),
    .q_avail          (q_avail),
    .q_used           (q_used),
    .virtio_interrupt (virtio_interrupt)
  );

  // Bus tasks run from edge+1; the handshake edge carries the optional irq/pop side actions.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic irq, input logic pop);
    int n;
    bus.awaddr = {20'h0, a}; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    #1;
    n = 0;
    while (!bus.awready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.awready) begin checks++; $display("FAIL awready_timeout: awready=0 required 1"); end
    irq_raise = irq; notify_ready = pop;
    @(posedge clk); #1;
    irq_raise = 1'b0; notify_ready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.bvalid) begin checks++; $display("FAIL bvalid_timeout: bvalid=0 required 1"); end
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n;
    bus.araddr = {20'h0, a}; bus.arvalid = 1'b1; bus.rready = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.arready) begin checks++; $display("FAIL arready_timeout: arready=0 required 1"); end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.rvalid) begin checks++; $display("FAIL rvalid_timeout: rvalid=0 required 1"); end
    d = bus.rdata;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b10000)
      $display("FAIL reset_handshake: got %b required 10000",
               {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
    else passes++;
    checks++;
    if ({notify_valid, virtio_interrupt, q_ready} !== 4'b0)
      $display("FAIL reset_flags: got %b required 0000", {notify_valid, virtio_interrupt, q_ready});
    else passes++;
    checks++;
    if ({q_num, q_desc, q_avail, q_used} !== '0) $display("FAIL reset_q_outputs: nonzero");
    else passes++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    axi_read(12'h034, d);
    checks++;
    if (d !== 32'd8) $display("FAIL reset_numax: got %h required 00000008", d); else passes++;
  endtask

  task automatic test_id_regs();
    logic [31:0] d;
    axi_read(12'h000, d);
    checks++; if (d !== 32'h7472_6976) $display("FAIL magic: got %h required 74726976", d); else passes++;
    axi_read(12'h004, d);
    checks++; if (d !== 32'd2) $display("FAIL version: got %h required 00000002", d); else passes++;
    axi_read(12'h008, d);
    checks++; if (d !== 32'd2) $display("FAIL device_id: got %h required 00000002", d); else passes++;
    axi_read(12'h100, d);
    checks++; if (d !== 32'd0) $display("FAIL unmapped: got %h required 00000000", d); else passes++;
    axi_write(12'h030, 32'd5, 4'hF, 1'b0, 1'b0);
    axi_read(12'h034, d);
    checks++; if (d !== 32'd0) $display("FAIL numax_sel5: got %h required 00000000", d); else passes++;
    axi_read(12'h030, d);
    checks++; if (d !== 32'd5) $display("FAIL queue_sel: got %h required 00000005", d); else passes++;
  endtask

  task automatic test_queue_num();
    logic [31:0] d;
    axi_write(12'h038, 32'd4, 4'hF, 1'b0, 1'b0);
    checks++; if (q_num !== 32'h0) $display("FAIL num_sel5_discard: got %h required 0", q_num); else passes++;
    axi_write(12'h030, 32'd1, 4'hF, 1'b0, 1'b0);
    axi_write(12'h038, 32'd9, 4'hF, 1'b0, 1'b0);
    checks++; if (q_num !== 32'h0) $display("FAIL num_9_discard: got %h required 0", q_num); else passes++;
    axi_write(12'h038, 32'd8, 4'hF, 1'b0, 1'b0);
    checks++; if (q_num[31:16] !== 16'd8) $display("FAIL num_8: got %h required 0008", q_num[31:16]); else passes++;
    axi_write(12'h038, 32'd0, 4'hF, 1'b0, 1'b0);
    checks++; if (q_num !== 32'h0008_0000) $display("FAIL num_0_discard: got %h required 00080000", q_num); else passes++;
    axi_read(12'h038, d);
    checks++; if (d !== 32'd8) $display("FAIL num_read: got %h required 00000008", d); else passes++;
    // Only byte 0 written: 0x0008 merged with 0x..04 -> 4.
    axi_write(12'h038, 32'h0000_0304, 4'h1, 1'b0, 1'b0);
    checks++; if (q_num[31:16] !== 16'd4) $display("FAIL num_strb: got %h required 0004", q_num[31:16]); else passes++;
    axi_write(12'h080, 32'hAABB_CCDD, 4'hF, 1'b0, 1'b0);
    axi_write(12'h080, 32'h1122_3344, 4'h5, 1'b0, 1'b0);
    checks++; if (q_desc !== 64'hAA22_CC44_0000_0000) $display("FAIL desc_strb: got %h required aa22cc4400000000", q_desc); else passes++;
    axi_write(12'h0A0, 32'h0000_1000, 4'hF, 1'b0, 1'b0);
    checks++; if (q_used !== 64'h0000_1000_0000_0000) $display("FAIL used_write: got %h required 0000100000000000", q_used); else passes++;
  endtask

  task automatic test_notify();
    logic [31:0] d;
    int n;
    axi_write(12'h030, 32'd0, 4'hF, 1'b0, 1'b0);
    axi_write(12'h044, 32'd1, 4'hF, 1'b0, 1'b0);
    checks++; if (q_ready !== 2'b01) $display("FAIL ready0: got %b required 01", q_ready); else passes++;
    for (int i = 0; i < 5; i++) axi_write(12'h050, 32'd0, 4'hF, 1'b0, 1'b0);
    checks++; if ({notify_valid, notify_queue} !== 2'b10) $display("FAIL notify_head: got %b required 10", {notify_valid, notify_queue}); else passes++;
    axi_read(12'h0FC, d);
    checks++; if (d !== 32'd1) $display("FAIL ovf_set: got %h required 00000001", d); else passes++;
    axi_read(12'h0FC, d);
    checks++; if (d !== 32'd0) $display("FAIL ovf_clear: got %h required 00000000", d); else passes++;
    axi_write(12'h050, 32'd1, 4'hF, 1'b0, 1'b0);   // queue 1 not ready: discarded
    axi_write(12'h050, 32'd0, 4'hF, 1'b0, 1'b1);   // full, push with pop: both succeed
    axi_read(12'h0FC, d);
    checks++; if (d !== 32'd0) $display("FAIL ovf_push_pop: got %h required 00000000", d); else passes++;
    notify_ready = 1'b1;
    n = 0;
    while (notify_valid && n < 10) begin @(posedge clk); #1; n++; end
    notify_ready = 1'b0;
    checks++; if (n !== 4) $display("FAIL fifo_count: got %0d required 4", n); else passes++;
    axi_write(12'h030, 32'd1, 4'hF, 1'b0, 1'b0);
    axi_write(12'h044, 32'd1, 4'hF, 1'b0, 1'b0);
    axi_write(12'h050, 32'd1, 4'hF, 1'b0, 1'b0);
    axi_write(12'h050, 32'd0, 4'hF, 1'b0, 1'b0);
    checks++; if ({q_ready, notify_valid, notify_queue} !== 4'b1111) $display("FAIL notify_q1: got %b required 1111", {q_ready, notify_valid, notify_queue}); else passes++;
    notify_ready = 1'b1; @(posedge clk); #1; notify_ready = 1'b0;
    checks++; if ({notify_valid, notify_queue} !== 2'b10) $display("FAIL notify_q0: got %b required 10", {notify_valid, notify_queue}); else passes++;
    notify_ready = 1'b1; @(posedge clk); #1; notify_ready = 1'b0;
    checks++; if (notify_valid !== 1'b0) $display("FAIL notify_empty: got %b required 0", notify_valid); else passes++;
  endtask

  task automatic test_irq();
    logic [31:0] d;
    axi_write(12'h064, 32'd1, 4'hF, 1'b1, 1'b0);
    axi_read(12'h060, d);
    checks++; if (d !== 32'd1) $display("FAIL irq_set_wins: got %h required 00000001", d); else passes++;
    checks++; if (virtio_interrupt !== 1'b1) $display("FAIL irq_level: got %b required 1", virtio_interrupt); else passes++;
    axi_write(12'h064, 32'd1, 4'hF, 1'b0, 1'b0);
    axi_read(12'h060, d);
    checks++; if (d !== 32'd0 || virtio_interrupt !== 1'b0) $display("FAIL irq_ack: got %h/%b required 00000000/0", d, virtio_interrupt); else passes++;
    axi_write(12'h070, 32'h40, 4'hF, 1'b0, 1'b0);
    axi_read(12'h060, d);
    checks++; if (d !== 32'd2) $display("FAIL needs_reset: got %h required 00000002", d); else passes++;
    axi_read(12'h070, d);
    checks++; if (d !== 32'h40) $display("FAIL status_read: got %h required 00000040", d); else passes++;
    axi_write(12'h064, 32'd2, 4'hF, 1'b0, 1'b0);
    checks++; if (virtio_interrupt !== 1'b0) $display("FAIL irq_ack2: got %b required 0", virtio_interrupt); else passes++;
  endtask

  task automatic test_dev_reset();
    logic [31:0] d;
    axi_write(12'h050, 32'd0, 4'hF, 1'b0, 1'b0);
    checks++; if ({q_ready, notify_valid} !== 3'b111) $display("FAIL devrst_pre: got %b required 111", {q_ready, notify_valid}); else passes++;
    axi_write(12'h070, 32'h0, 4'hF, 1'b0, 1'b0);
    checks++; if ({q_ready, notify_valid} !== 3'b000) $display("FAIL devrst_clear: got %b required 000", {q_ready, notify_valid}); else passes++;
    checks++; if ({q_num, q_desc, q_used} !== '0) $display("FAIL devrst_regs: q_num=%h q_desc=%h required 0", q_num, q_desc); else passes++;
    axi_read(12'h030, d);
    checks++; if (d !== 32'd0) $display("FAIL devrst_sel: got %h required 00000000", d); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus.awaddr = 32'h030; bus.wdata = 32'd3; bus.wstrb = 4'hF; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = 32'h030; bus.arvalid = 1'b1; bus.rready = 1'b0;
    #1;
    checks++; if ({bus.awready, bus.wready} !== 2'b00) $display("FAIL aw_only: got %b required 00", {bus.awready, bus.wready}); else passes++;
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.wvalid = 1'b1;
    #1;
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b110) $display("FAIL aw_w_both: got %b required 110", {bus.awready, bus.wready, bus.arready}); else passes++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'd0}) $display("FAIL r_hold: got %b/%h required 1/00000000", bus.rvalid, bus.rdata); else passes++;
    end
    checks++; if ({bus.bvalid, bus.awready} !== 2'b10) $display("FAIL b_hold: got %b required 10", {bus.bvalid, bus.awready}); else passes++;
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.bready = 1'b0;
    checks++; if ({bus.rvalid, bus.bvalid} !== 2'b00) $display("FAIL rb_done: got %b required 00", {bus.rvalid, bus.bvalid}); else passes++;
    axi_read(12'h030, d);
    checks++; if (d !== 32'd3) $display("FAIL sel_after: got %h required 00000003", d); else passes++;
    // Read and write of QueueSel on the same edge: read returns the old value.
    bus.awaddr = 32'h030; bus.wdata = 32'd7; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; bus.rready = 1'b1; bus.bready = 1'b1;
    checks++; if (bus.rdata !== 32'd3) $display("FAIL same_cycle_rw: got %h required 00000003", bus.rdata); else passes++;
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.bready = 1'b0;
    axi_read(12'h030, d);
    checks++; if (d !== 32'd7) $display("FAIL sel_written: got %h required 00000007", d); else passes++;
  endtask

  task automatic test_rst_mid();
    bus.awaddr = 32'h030; bus.wdata = 32'd1; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    bus.araddr = 32'h000; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checks++; if ({bus.rvalid, bus.bvalid} !== 2'b11) $display("FAIL mid_pre: got %b required 11", {bus.rvalid, bus.bvalid}); else passes++;
    rst = 1'b1;
    #1;
    checks++; if ({bus.rvalid, bus.bvalid, bus.arready} !== 3'b001) $display("FAIL mid_abort: got %b required 001", {bus.rvalid, bus.bvalid, bus.arready}); else passes++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; notify_ready = 1'b0; irq_raise = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_id_regs();
    test_queue_num();
    test_notify();
    test_irq();
    test_dev_reset();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
